ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of a five-stage MIPS-style pipeline.
//   Computes the ALU / shift / set-less-than / immediate result for the
//   instruction held in ID/EX and registers it into EX/MEM together with
//   the store data, the destination register and the MEM/WB control fields.
//   Optional iterative multiply/divide unit with HI/LO registers, enabled by
//   defining the macro EX_MULDIV_EN (default build: unit absent).
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_regA, i_regB, i_extendido : operands and sign-extended immediate
//   i_opcode, i_rt, i_rd        : opcode and candidate destinations
//   i_ex  [3]=RegDst [2:1]=ALUOp [0]=ALUSrc ; i_mem, i_wb : passed control
//   o_result, o_regB, o_write_reg, o_mem, o_wb : registered EX/MEM contents
//   o_stall : combinational hold request to ID/EX ; o_busy : mul/div iterating
module ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZEOP     = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_regA,
    input  logic [DATA_WIDTH-1:0] i_regB,
    input  logic [DATA_WIDTH-1:0] i_extendido,
    input  logic [SIZEOP-1:0]     i_opcode,
    input  logic [4:0]            i_rt,
    input  logic [4:0]            i_rd,
    input  logic [3:0]            i_ex,
    input  logic [2:0]            i_mem,
    input  logic [1:0]            i_wb,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [DATA_WIDTH-1:0] o_regB,
    output logic [4:0]            o_write_reg,
    output logic [2:0]            o_mem,
    output logic [1:0]            o_wb,
    output logic                  o_stall,
    output logic                  o_busy
);
    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
    localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;
    localparam logic [SIZEOP-1:0] OP_ADDIU = SIZEOP'(6'h09), OP_SLTI = SIZEOP'(6'h0A);
    localparam logic [SIZEOP-1:0] OP_SLTIU = SIZEOP'(6'h0B), OP_ANDI = SIZEOP'(6'h0C);
    localparam logic [SIZEOP-1:0] OP_ORI   = SIZEOP'(6'h0D), OP_XORI = SIZEOP'(6'h0E);
    localparam logic [SIZEOP-1:0] OP_LUI   = SIZEOP'(6'h0F);

    logic [5:0]            funct_s;
    logic [4:0]            shamt_s;
    logic [DATA_WIDTH-1:0] op_b_s, imm_zext_s, imm_lui_s, alu_result_s;
    logic                  stall_s;
    logic [1:0]            wb_s;

    assign funct_s    = i_extendido[5:0];
    assign shamt_s    = i_extendido[10:6];
    assign op_b_s     = i_ex[0] ? i_extendido : i_regB;
    assign imm_zext_s = {{(DATA_WIDTH-16){1'b0}}, i_extendido[15:0]};
    assign imm_lui_s  = {i_extendido[15:0], {(DATA_WIDTH-16){1'b0}}};

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} md_state_t;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    // Two's-complement negate when neg is set (magnitude / sign fix-up).
    function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                       input logic neg);
        if (neg) begin
            return ~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    md_state_t               state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [DATA_WIDTH-1:0]   hi_r, lo_r, work_hi_r, work_lo_r, div_b_r, dividend_r;
    logic                    is_div_r, neg_q_r, neg_r_r, dz_r;
    logic                    is_muldiv_s, is_mf_s, start_s, signed_s, a_neg_s, b_neg_s;
    logic [DATA_WIDTH:0]     mul_sum_s, div_shift_s, div_trial_s;
    logic [DATA_WIDTH-1:0]   step_hi_s, step_lo_s, fin_hi_s, fin_lo_s;
    logic [2*DATA_WIDTH-1:0] prod_s;

    assign is_muldiv_s = (i_ex[2:1] == 2'b10) &&
                         ((funct_s == F_MULT) || (funct_s == F_MULTU) ||
                          (funct_s == F_DIV)  || (funct_s == F_DIVU));
    assign is_mf_s     = (i_ex[2:1] == 2'b10) && ((funct_s == F_MFHI) || (funct_s == F_MFLO));
    assign start_s     = is_muldiv_s && (state_r != ST_BUSY);
    assign signed_s    = (funct_s == F_MULT) || (funct_s == F_DIV);
    assign a_neg_s     = signed_s && i_regA[DATA_WIDTH-1];
    assign b_neg_s     = signed_s && i_regB[DATA_WIDTH-1];
    assign stall_s     = (is_muldiv_s || is_mf_s) && (state_r == ST_BUSY);
    assign o_stall     = stall_s;
    assign o_busy      = (state_r == ST_BUSY);

    // One radix-2 iteration: shift-add multiply or restoring divide, plus final fix-up.
    always_comb begin
        mul_sum_s   = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, div_b_r} : {(DATA_WIDTH+1){1'b0}});
        div_shift_s = {work_hi_r, work_lo_r[DATA_WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, div_b_r};
        if (is_div_r) begin
            // Trial MSB clear means the shifted remainder covered the divisor.
            if (!div_trial_s[DATA_WIDTH]) begin
                step_hi_s = div_trial_s[DATA_WIDTH-1:0];
                step_lo_s = {work_lo_r[DATA_WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[DATA_WIDTH-1:0];
                step_lo_s = {work_lo_r[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[DATA_WIDTH:1];
            step_lo_s = {mul_sum_s[0], work_lo_r[DATA_WIDTH-1:1]};
        end
        prod_s = {step_hi_s, step_lo_s};
        if (dz_r) begin
            fin_lo_s = {DATA_WIDTH{1'b1}};
            fin_hi_s = dividend_r;
        end else if (is_div_r) begin
            fin_lo_s = cond_neg(step_lo_s, neg_q_r);
            fin_hi_s = cond_neg(step_hi_s, neg_r_r);
        end else if (neg_q_r) begin
            prod_s   = ~prod_s + {{(2*DATA_WIDTH-1){1'b0}}, 1'b1};
            fin_hi_s = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            fin_lo_s = prod_s[DATA_WIDTH-1:0];
        end else begin
            fin_hi_s = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            fin_lo_s = prod_s[DATA_WIDTH-1:0];
        end
    end

    // Mul/div FSM: accepts in IDLE/DONE, iterates DATA_WIDTH cycles, writes HI/LO.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            hi_r       <= '0;
            lo_r       <= '0;
            work_hi_r  <= '0;
            work_lo_r  <= '0;
            div_b_r    <= '0;
            dividend_r <= '0;
            is_div_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            dz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_BUSY: begin
                    work_hi_r <= step_hi_s;
                    work_lo_r <= step_lo_s;
                    if (cnt_r == CNT_LAST) begin
                        hi_r    <= fin_hi_s;
                        lo_r    <= fin_lo_s;
                        cnt_r   <= '0;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (start_s) begin
                        work_hi_r  <= '0;
                        work_lo_r  <= cond_neg(i_regA, a_neg_s);
                        div_b_r    <= cond_neg(i_regB, b_neg_s);
                        dividend_r <= i_regA;
                        is_div_r   <= (funct_s == F_DIV) || (funct_s == F_DIVU);
                        neg_q_r    <= a_neg_s ^ b_neg_s;
                        neg_r_r    <= a_neg_s;
                        dz_r       <= ((funct_s == F_DIV) || (funct_s == F_DIVU)) &&
                                      (i_regB == '0);
                        cnt_r      <= '0;
                        state_r    <= ST_BUSY;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Mul/div instructions travel down the pipe but never write a GPR.
    always_comb begin
        if (is_muldiv_s) begin
            wb_s = 2'b00;
        end else begin
            wb_s = i_wb;
        end
    end
`else
    assign stall_s = 1'b0;
    assign o_stall = 1'b0;
    assign o_busy  = 1'b0;
    assign wb_s    = i_wb;
`endif

    // ALU result selection by ALUOp, then funct or opcode.
    always_comb begin
        alu_result_s = '0;
        case (i_ex[2:1])
            2'b00: alu_result_s = i_regA + op_b_s;
            2'b01: alu_result_s = i_regA - op_b_s;
            2'b10: begin
                case (funct_s)
                    F_SLL:  alu_result_s = i_regB << shamt_s;
                    F_SRL:  alu_result_s = i_regB >> shamt_s;
                    F_SRA:  alu_result_s = $signed(i_regB) >>> shamt_s;
`ifdef EX_MULDIV_EN
                    F_MFHI: alu_result_s = hi_r;
                    F_MFLO: alu_result_s = lo_r;
`endif
                    F_ADDU: alu_result_s = i_regA + op_b_s;
                    F_SUBU: alu_result_s = i_regA - op_b_s;
                    F_AND:  alu_result_s = i_regA & op_b_s;
                    F_OR:   alu_result_s = i_regA | op_b_s;
                    F_XOR:  alu_result_s = i_regA ^ op_b_s;
                    F_NOR:  alu_result_s = ~(i_regA | op_b_s);
                    F_SLT:  alu_result_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_regA) < $signed(op_b_s))};
                    F_SLTU: alu_result_s = {{(DATA_WIDTH-1){1'b0}}, (i_regA < op_b_s)};
                    default: alu_result_s = '0;
                endcase
            end
            2'b11: begin
                case (i_opcode)
                    OP_ADDIU: alu_result_s = i_regA + i_extendido;
                    OP_SLTI:  alu_result_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_regA) < $signed(i_extendido))};
                    OP_SLTIU: alu_result_s = {{(DATA_WIDTH-1){1'b0}}, (i_regA < i_extendido)};
                    OP_ANDI:  alu_result_s = i_regA & imm_zext_s;
                    OP_ORI:   alu_result_s = i_regA | imm_zext_s;
                    OP_XORI:  alu_result_s = i_regA ^ imm_zext_s;
                    OP_LUI:   alu_result_s = imm_lui_s;
                    default:  alu_result_s = '0;
                endcase
            end
            default: alu_result_s = '0;
        endcase
    end

    // EX/MEM pipeline register; a stall loads an all-zero bubble.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_result    <= '0;
            o_regB      <= '0;
            o_write_reg <= 5'd0;
            o_mem       <= 3'd0;
            o_wb        <= 2'd0;
        end else if (stall_s) begin
            o_result    <= '0;
            o_regB      <= '0;
            o_write_reg <= 5'd0;
            o_mem       <= 3'd0;
            o_wb        <= 2'd0;
        end else begin
            o_result    <= alu_result_s;
            o_regB      <= i_regB;
            o_write_reg <= i_ex[3] ? i_rd : i_rt;
            o_mem       <= i_mem;
            o_wb        <= wb_s;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
    logic        i_clock, i_reset;
    logic [31:0] i_regA, i_regB, i_extendido;
    logic [5:0]  i_opcode;
    logic [4:0]  i_rt, i_rd;
    logic [3:0]  i_ex;
    logic [2:0]  i_mem;
    logic [1:0]  i_wb;
    logic [31:0] o_result, o_regB;
    logic [4:0]  o_write_reg;
    logic [2:0]  o_mem;
    logic [1:0]  o_wb;
    logic        o_stall, o_busy;
    int total = 0;
    int bad   = 0;

    ex_stage #(.DATA_WIDTH(32), .SIZEOP(6)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_regA(i_regA), .i_regB(i_regB),
        .i_extendido(i_extendido), .i_opcode(i_opcode), .i_rt(i_rt), .i_rd(i_rd),
        .i_ex(i_ex), .i_mem(i_mem), .i_wb(i_wb), .o_result(o_result), .o_regB(o_regB),
        .o_write_reg(o_write_reg), .o_mem(o_mem), .o_wb(o_wb), .o_stall(o_stall),
        .o_busy(o_busy)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic [5:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    // R-type vectors: funct, regA, regB/ext, shamt, expected result
    vec_t rvec [14] = '{
        '{6'h03, 32'h0,        32'h80000000, 5'd4, 32'hF8000000},
        '{6'h02, 32'h0,        32'h80000000, 5'd4, 32'h08000000},
        '{6'h00, 32'h0,        32'h00000003, 5'd4, 32'h00000030},
        '{6'h23, 32'h5,        32'h7,        5'd0, 32'hFFFFFFFE},
        '{6'h24, 32'hF0F000FF, 32'h0FF00F0F, 5'd0, 32'h00F0000F},
        '{6'h25, 32'hF0F000FF, 32'h0FF00F0F, 5'd0, 32'hFFF00FFF},
        '{6'h26, 32'hF0F000FF, 32'h0FF00F0F, 5'd0, 32'hFF000FF0},
        '{6'h27, 32'hF0F000FF, 32'h0FF00F0F, 5'd0, 32'h000FF000},
        '{6'h2A, 32'hFFFFFFFF, 32'h1,        5'd0, 32'h1},
        '{6'h2B, 32'hFFFFFFFF, 32'h1,        5'd0, 32'h0},
        '{6'h2A, 32'h1,        32'hFFFFFFFF, 5'd0, 32'h0},
        '{6'h2B, 32'h1,        32'hFFFFFFFF, 5'd0, 32'h1},
        '{6'h21, 32'hFFFFFFFF, 32'h2,        5'd0, 32'h1},
        '{6'h3F, 32'h5,        32'h5,        5'd0, 32'h0}
    };

    // I-type vectors (ALUOp 11): opcode, regA, extendido, unused, expected
    vec_t ivec [9] = '{
        '{6'h0F, 32'h0,        32'h00001234, 5'd0, 32'h12340000},
        '{6'h0C, 32'hFFFFFFFF, 32'hFFFF8000, 5'd0, 32'h00008000},
        '{6'h0D, 32'h00010000, 32'hFFFF00F0, 5'd0, 32'h000100F0},
        '{6'h0E, 32'h000000FF, 32'h0000000F, 5'd0, 32'h000000F0},
        '{6'h09, 32'h5,        32'hFFFFFFFF, 5'd0, 32'h4},
        '{6'h0A, 32'h5,        32'hFFFFFFFF, 5'd0, 32'h0},
        '{6'h0B, 32'h5,        32'hFFFFFFFF, 5'd0, 32'h1},
        '{6'h0A, 32'hFFFFFFFE, 32'h1,        5'd0, 32'h1},
        '{6'h23, 32'h5,        32'h5,        5'd0, 32'h0}
    };

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] ex, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ext, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [2:0] mem, input logic [1:0] wb);
        i_ex = ex; i_opcode = op; i_regA = a; i_regB = b; i_extendido = ext;
        i_rt = rt; i_rd = rd; i_mem = mem; i_wb = wb;
    endtask

    task automatic drive_r(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh);
        drive(4'b1100, 6'h00, a, b, {21'h0, sh, funct}, 5'd9, 5'd5, 3'b001, 2'b11);
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        drive_r(6'h21, 32'h1, 32'h1, 5'd0);
        tick(); tick();
        total++; if (o_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", o_result); end
        total++; if (o_regB !== 32'h0) begin bad++; $display("FAIL reset_regB got=%h exp=0", o_regB); end
        total++; if ({o_write_reg, o_mem, o_wb} !== 10'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", {o_write_reg, o_mem, o_wb}); end
        total++; if ({o_stall, o_busy} !== 2'b00) begin bad++; $display("FAIL reset_stall_busy got=%b exp=00", {o_stall, o_busy}); end
        i_reset = 1'b1;
        tick();
        total++; if (o_result !== 32'h2) begin bad++; $display("FAIL first_capture got=%h exp=2", o_result); end
    endtask

    task automatic test_addu();
        drive_r(6'h21, 32'h7, 32'hFFFFFFFD, 5'd0);
        tick();
        total++; if (o_result !== 32'h4) begin bad++; $display("FAIL addu_result got=%h exp=4", o_result); end
        total++; if (o_write_reg !== 5'd5) begin bad++; $display("FAIL addu_write_reg got=%0d exp=5", o_write_reg); end
        total++; if (o_regB !== 32'hFFFFFFFD) begin bad++; $display("FAIL addu_regB got=%h exp=fffffffd", o_regB); end
        total++; if ({o_mem, o_wb} !== 5'b001_11) begin bad++; $display("FAIL addu_ctrl got=%b exp=00111", {o_mem, o_wb}); end
    endtask

    task automatic test_funct();
        for (int i = 0; i < 14; i++) begin
            drive_r(rvec[i].code, rvec[i].a, rvec[i].b, rvec[i].sh);
            tick();
            total++;
            if (o_result !== rvec[i].exp) begin
                bad++; $display("FAIL funct_vec[%0d] f=%h got=%h exp=%h", i, rvec[i].code, o_result, rvec[i].exp);
            end
        end
    endtask

    task automatic test_imm();
        for (int i = 0; i < 9; i++) begin
            drive(4'b0111, ivec[i].code, ivec[i].a, 32'hDEADBEEF, ivec[i].b, 5'd12, 5'd3, 3'b010, 2'b01);
            tick();
            total++;
            if (o_result !== ivec[i].exp) begin
                bad++; $display("FAIL imm_vec[%0d] op=%h got=%h exp=%h", i, ivec[i].code, o_result, ivec[i].exp);
            end
        end
        total++; if (o_write_reg !== 5'd12) begin bad++; $display("FAIL imm_write_reg got=%0d exp=12", o_write_reg); end
    endtask

    task automatic test_addsub();
        drive(4'b0001, 6'h23, 32'hFFFFFFFF, 32'h100, 32'h1, 5'd7, 5'd2, 3'b100, 2'b10);
        tick();
        total++; if (o_result !== 32'h0) begin bad++; $display("FAIL add_wrap got=%h exp=0", o_result); end
        total++; if (o_write_reg !== 5'd7) begin bad++; $display("FAIL add_rt_dest got=%0d exp=7", o_write_reg); end
        drive(4'b0010, 6'h04, 32'h0, 32'h1, 32'h55, 5'd7, 5'd2, 3'b000, 2'b00);
        tick();
        total++; if (o_result !== 32'hFFFFFFFF) begin bad++; $display("FAIL sub_wrap got=%h exp=ffffffff", o_result); end
    endtask

`ifdef EX_MULDIV_EN
    // Wait, bounded, for o_stall to drop; returns cycles spent stalled.
    task automatic wait_unstall(output int n);
        n = 0;
        while (o_stall === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Issue a mul/div op, then read LO and HI back through MFLO/MFHI.
    task automatic md_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi, output int n);
        drive_r(f, a, b, 5'd0);
        tick();
        drive_r(6'h12, 32'h0, 32'h0, 5'd0);
        wait_unstall(n);
        tick();
        lo = o_result;
        drive_r(6'h10, 32'h0, 32'h0, 5'd0);
        tick();
        hi = o_result;
    endtask

    task automatic test_mult_stall();
        int n;
        int bubble_bad;
        drive_r(6'h18, 32'hFFFFFFFE, 32'h3, 5'd0);
        tick();
        total++; if (o_wb !== 2'b00) begin bad++; $display("FAIL mult_wb got=%b exp=00", o_wb); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL mult_busy got=%b exp=1", o_busy); end
        drive_r(6'h12, 32'h0, 32'h0, 5'd0);
        n = 0; bubble_bad = 0;
        while (o_stall === 1'b1 && n < 100) begin
            tick();
            n++;
            if ({o_result, o_regB, o_write_reg, o_mem, o_wb} !== 74'h0) bubble_bad++;
        end
        total++; if (n !== 32) begin bad++; $display("FAIL mult_stall_cycles got=%0d exp=32", n); end
        total++; if (bubble_bad !== 0) begin bad++; $display("FAIL mult_bubbles got=%0d_nonzero exp=0", bubble_bad); end
        tick();
        total++; if (o_result !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_mflo got=%h exp=fffffffa", o_result); end
        total++; if (o_write_reg !== 5'd5) begin bad++; $display("FAIL mflo_dest got=%0d exp=5", o_write_reg); end
        drive_r(6'h10, 32'h0, 32'h0, 5'd0);
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL mfhi_idle_stall got=%b exp=0", o_stall); end
        tick();
        total++; if (o_result !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_mfhi got=%h exp=ffffffff", o_result); end
    endtask

    task automatic test_divide();
        logic [31:0] lo, hi;
        int n;
        md_op(6'h1A, 32'h7, 32'h0, lo, hi, n);
        total++; if ({hi, lo} !== {32'h7, 32'hFFFFFFFF}) begin bad++; $display("FAIL div_by_zero got=%h_%h exp=00000007_ffffffff", hi, lo); end
        md_op(6'h1A, 32'hFFFFFFF9, 32'h2, lo, hi, n);
        total++; if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin bad++; $display("FAIL div_neg got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
        md_op(6'h1A, 32'hFFFFFFF9, 32'h0, lo, hi, n);
        total++; if ({hi, lo} !== {32'hFFFFFFF9, 32'hFFFFFFFF}) begin bad++; $display("FAIL div_neg_by_zero got=%h_%h exp=fffffff9_ffffffff", hi, lo); end
        md_op(6'h1B, 32'd100, 32'd7, lo, hi, n);
        total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu got=%h_%h exp=00000002_0000000e", hi, lo); end
        md_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, lo, hi, n);
        total++; if ({hi, lo} !== {32'hFFFFFFFE, 32'h1}) begin bad++; $display("FAIL multu_max got=%h_%h exp=fffffffe_00000001", hi, lo); end
        total++; if (n >= 100) begin bad++; $display("FAIL md_timeout got=%0d exp=<100", n); end
    endtask

    task automatic test_back_to_back();
        int n;
        drive_r(6'h1B, 32'd100, 32'd7, 5'd0);
        tick();
        drive_r(6'h19, 32'd6, 32'd7, 5'd0);
        wait_unstall(n);
        total++; if (n !== 32) begin bad++; $display("FAIL b2b_stall got=%0d exp=32", n); end
        tick();
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_done got=%b exp=1", o_busy); end
        drive_r(6'h12, 32'h0, 32'h0, 5'd0);
        wait_unstall(n);
        tick();
        total++; if (o_result !== 32'd42) begin bad++; $display("FAIL b2b_mflo got=%h exp=0000002a", o_result); end
    endtask

    task automatic test_reset_midbusy();
        drive_r(6'h1B, 32'd100, 32'd7, 5'd0);
        tick();
        drive_r(6'h21, 32'h1, 32'h1, 5'd0);
        repeat (9) tick();
        total++; if ({o_busy, o_stall} !== 2'b10) begin bad++; $display("FAIL midbusy_state got=%b exp=10", {o_busy, o_stall}); end
        total++; if (o_result !== 32'h2) begin bad++; $display("FAIL addu_during_busy got=%h exp=2", o_result); end
        i_reset = 1'b0;
        #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        total++; if (o_result !== 32'h0) begin bad++; $display("FAIL reset_async_result got=%h exp=0", o_result); end
        i_reset = 1'b1;
        drive_r(6'h10, 32'h0, 32'h0, 5'd0);
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_mfhi_stall got=%b exp=0", o_stall); end
        tick();
        total++; if (o_result !== 32'h0) begin bad++; $display("FAIL reset_mfhi got=%h exp=0", o_result); end
    endtask
`else
    task automatic test_muldiv_absent();
        drive_r(6'h18, 32'hFFFFFFFE, 32'h3, 5'd0);
        total++; if ({o_stall, o_busy} !== 2'b00) begin bad++; $display("FAIL nomd_stall_busy got=%b exp=00", {o_stall, o_busy}); end
        tick();
        total++; if (o_result !== 32'h0) begin bad++; $display("FAIL nomd_mult got=%h exp=0", o_result); end
        drive_r(6'h12, 32'h5, 32'h5, 5'd0);
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL nomd_mflo_stall got=%b exp=0", o_stall); end
        tick();
        total++; if (o_result !== 32'h0) begin bad++; $display("FAIL nomd_mflo got=%h exp=0", o_result); end
        drive_r(6'h10, 32'h5, 32'h5, 5'd0);
        tick();
        total++; if (o_result !== 32'h0) begin bad++; $display("FAIL nomd_mfhi got=%h exp=0", o_result); end
        drive_r(6'h1A, 32'h7, 32'h0, 5'd0);
        tick();
        total++; if (o_result !== 32'h0) begin bad++; $display("FAIL nomd_div got=%h exp=0", o_result); end
    endtask
`endif

    initial begin
        test_reset();
        test_addu();
        test_funct();
        test_imm();
        test_addsub();
`ifdef EX_MULDIV_EN
        test_mult_stall();
        test_divide();
        test_back_to_back();
        test_reset_midbusy();
`else
        test_muldiv_absent();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
